tdc_meas_ctrl: RTL
==================

Name: tdc_meas_ctrl

Overview:
- Sequencer for the time_counter TDC datapath.
- Arms the counter, collects its o_time/wrena results and averages a burst of 2^LOG2_AVG samples.
- Delivers the mean through a valid/ready handshake; flags a timeout when the TDC stops producing results.
- Sits between the time_counter instance and the readout/host logic.

Parameters:
TIME_W, 12, width of TDC time code (o_time)
LOG2_AVG, 3, log2 of samples per burst (N = 8)
TIMEOUT, 4095, max clocks waited for one wrena before error (must be >= 2)
TMR_W, 12, timer width; must hold TIMEOUT-1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle request to begin a burst
abort  in  1  cancel burst in progress
tdc_time  in  TIME_W  o_time from time_counter
tdc_wrena  in  1  result strobe from time_counter
tdc_en  out  1  arms time_counter (high only in WAIT)
tdc_clr  out  1  one-cycle clear pulse to TDC (high only in ARM)
res_time  out  TIME_W  burst mean
res_valid  out  1  res_time valid
res_ready  in  1  consumer accepts result
busy  out  1  state != IDLE
err_timeout  out  1  sticky timeout flag
meas_cnt  out  LOG2_AVG  samples collected in current burst

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0; acc and timer 0.
- FSM states: IDLE, ARM, WAIT, DONE, ERR.
- IDLE:
  - start=1 -> ARM.
  - err_timeout clears on the edge start is sampled.
  - acc, meas_cnt and timer clear.
- ARM: tdc_clr=1 for exactly one cycle -> WAIT.
- WAIT: tdc_en=1; timer counts up every cycle.
  - tdc_wrena=1, not last sample: acc += tdc_time (accumulator TIME_W+LOG2_AVG bits, no overflow possible); meas_cnt++; timer=0; stay in WAIT.
  - tdc_wrena=1 on last sample (meas_cnt==N-1): res_time <= (acc+tdc_time) >> LOG2_AVG (truncate, no rounding); res_valid <= 1 -> DONE. Latency is one clock from the final wrena to res_valid.
  - tdc_wrena=0 and timer==TIMEOUT-1: err_timeout <= 1 -> ERR.
  - tdc_wrena and timeout in the same cycle: the sample wins and no error is raised.
- DONE:
  - res_valid held with res_time stable until res_ready=1.
  - On the accepting edge res_valid <= 0 -> IDLE.
  - res_ready while res_valid=0 is ignored.
- ERR: one cycle -> IDLE. err_timeout stays set; no result is produced.
- tdc_wrena outside WAIT is ignored (not accumulated).
- start while busy is ignored; there is no queueing.
- abort:
  - In ARM or WAIT -> IDLE next edge, partial accumulation discarded, err_timeout unchanged.
  - In DONE it is ignored; the pending result must still be handshaked.
  - abort and start together in IDLE: abort wins and the FSM stays IDLE.
- meas_cnt wraps to 0 when a burst completes; it reads 0 in DONE.
- tdc_time of 0 is a valid sample.

Optional Feature:
TDC_MINMAX_EN:
- Defined: adds outputs res_min and res_max (TIME_W each).
  - Min/max of the burst samples, initialised on the first sample of the burst.
  - Both updated on the same edge as res_time, valid under res_valid.
  - Reset to 0.
- Undefined: ports absent; no min/max registers.

Decomposition:
- Package tdc_pkg: state enum type (IDLE, ARM, WAIT, DONE, ERR) and a localparam helper for accumulator width (TIME_W+LOG2_AVG).
- Sub-module tdc_accum: sum register, running min/max under the macro, and clear/add controls.
- FSM and timer stay in the top module.

Test Plan:
- LOG2_AVG=2; start; wrena with 100, 104, 96, 101 -> res_time=100 (401>>2), res_valid one clock after the 4th wrena, busy=1 throughout.
- TIMEOUT=50; start; no wrena -> err_timeout rises 51 edges after start sampled; no res_valid; back to IDLE 1 clock later; next start clears err_timeout.
- res_ready held low 20 cycles after res_valid -> res_time stable and res_valid high; start during this window is ignored; res_ready=1 -> IDLE next edge.
- abort after 2 of 4 samples, then a new burst of 4x 200 -> res_time=200, proving the earlier partial sum was discarded.
- wrena coincident with timer==TIMEOUT-1 -> sample counted, no error; also async rst mid-WAIT -> all outputs 0 immediately.
- With TDC_MINMAX_EN: samples 7, 3, 9, 5 -> res_min=3, res_max=9, res_time=6.

Source files
------------

// File: rtl/tdc_pkg.sv
// tdc_pkg: shared FSM state type and accumulator width helper for tdc_meas_ctrl.
package tdc_pkg;
   typedef enum logic [2:0] {IDLE, ARM, WAIT, DONE, ERR} state_t;
   function automatic int acc_width(input int time_w, input int log2_avg);
      return time_w + log2_avg;
   endfunction
endpackage

// File: rtl/tdc_meas_ctrl_accum.sv
// tdc_accum: burst sum register with optional running min/max.
// Min/max tracking is built only when TDC_MINMAX_EN is defined.
module tdc_accum
   import tdc_pkg::*;
#(
   parameter int TIME_W   = 12,
   parameter int LOG2_AVG = 3,
   localparam int ACC_W   = acc_width(TIME_W, LOG2_AVG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              add,
   input  logic [TIME_W-1:0] sample,
`ifdef TDC_MINMAX_EN
   input  logic              first,
   output logic [TIME_W-1:0] min_nx,
   output logic [TIME_W-1:0] max_nx,
`endif
   output logic [ACC_W-1:0]  sum_nx
);
   logic [ACC_W-1:0] acc_q, acc_d;
   always_comb begin
      sum_nx = acc_q + ACC_W'(sample);
      acc_d  = clr ? '0 : add ? sum_nx : acc_q;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) acc_q <= '0;
      else     acc_q <= acc_d;
`ifdef TDC_MINMAX_EN
   logic [TIME_W-1:0] min_q, max_q, min_d, max_d;
   // the first sample of a burst seeds both extremes
   always_comb begin
      min_nx = (first || sample < min_q) ? sample : min_q;
      max_nx = (first || sample > max_q) ? sample : max_q;
      min_d  = clr ? '0 : add ? min_nx : min_q;
      max_d  = clr ? '0 : add ? max_nx : max_q;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         min_q <= '0;
         max_q <= '0;
      end else begin
         min_q <= min_d;
         max_q <= max_d;
      end
`endif
endmodule

// File: rtl/tdc_meas_ctrl.sv
// tdc_meas_ctrl: arms the TDC, averages 2^LOG2_AVG results, hands the mean out via valid/ready.
// Define TDC_MINMAX_EN to add res_min/res_max burst extremes.
module tdc_meas_ctrl
   import tdc_pkg::*;
#(
   parameter int TIME_W   = 12,
   parameter int LOG2_AVG = 3,
   parameter int TIMEOUT  = 4095,
   parameter int TMR_W    = 12
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [TIME_W-1:0]   tdc_time,
   input  logic                tdc_wrena,
   output logic                tdc_en,
   output logic                tdc_clr,
   output logic [TIME_W-1:0]   res_time,
   output logic                res_valid,
   input  logic                res_ready,
   output logic                busy,
   output logic                err_timeout,
`ifdef TDC_MINMAX_EN
   output logic [TIME_W-1:0]   res_min,
   output logic [TIME_W-1:0]   res_max,
`endif
   output logic [LOG2_AVG-1:0] meas_cnt
);
   localparam int ACC_W = acc_width(TIME_W, LOG2_AVG);

   state_t              state_q, state_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [LOG2_AVG-1:0] meas_cnt_q, meas_cnt_d;
   logic                err_q, err_d;
   logic [TIME_W-1:0]   res_time_q, res_time_d;
   logic                res_valid_q, res_valid_d;
   logic                acc_clr, acc_add, last;
   logic [ACC_W-1:0]    sum_nx;

`ifdef TDC_MINMAX_EN
   logic [TIME_W-1:0] min_nx, max_nx, res_min_q, res_min_d, res_max_q, res_max_d;
`endif

   tdc_accum #(.TIME_W(TIME_W), .LOG2_AVG(LOG2_AVG)) u_accum (
      .clk    (clk),
      .rst    (rst),
      .clr    (acc_clr),
      .add    (acc_add),
      .sample (tdc_time),
`ifdef TDC_MINMAX_EN
      .first  (meas_cnt_q == '0),
      .min_nx (min_nx),
      .max_nx (max_nx),
`endif
      .sum_nx (sum_nx)
   );

   assign last = meas_cnt_q == LOG2_AVG'((1 << LOG2_AVG) - 1);

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      meas_cnt_d  = meas_cnt_q;
      err_d       = err_q;
      res_time_d  = res_time_q;
      res_valid_d = res_valid_q;
      acc_clr     = 1'b0;
      acc_add     = 1'b0;
`ifdef TDC_MINMAX_EN
      res_min_d   = res_min_q;
      res_max_d   = res_max_q;
`endif
      case (state_q)
         IDLE: begin
            acc_clr    = 1'b1;
            timer_d    = '0;
            meas_cnt_d = '0;
            if (start && !abort) begin
               state_d = ARM;
               err_d   = 1'b0;
            end
         end
         ARM: begin
            timer_d = '0;
            state_d = abort ? IDLE : WAIT;
         end
         WAIT: begin
            timer_d = timer_q + 1'b1;
            if (abort) begin
               state_d    = IDLE;
               timer_d    = '0;
               meas_cnt_d = '0;
            end else if (tdc_wrena) begin
               // a sample arriving on the timeout cycle still counts
               acc_add    = 1'b1;
               timer_d    = '0;
               meas_cnt_d = meas_cnt_q + 1'b1;
               if (last) begin
                  res_time_d  = TIME_W'(sum_nx >> LOG2_AVG);
                  res_valid_d = 1'b1;
                  state_d     = DONE;
`ifdef TDC_MINMAX_EN
                  res_min_d   = min_nx;
                  res_max_d   = max_nx;
`endif
               end
            end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = ERR;
            end
         end
         DONE: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         ERR: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q     <= IDLE;
         timer_q     <= '0;
         meas_cnt_q  <= '0;
         err_q       <= 1'b0;
         res_time_q  <= '0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         meas_cnt_q  <= meas_cnt_d;
         err_q       <= err_d;
         res_time_q  <= res_time_d;
         res_valid_q <= res_valid_d;
      end

`ifdef TDC_MINMAX_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         res_min_q <= '0;
         res_max_q <= '0;
      end else begin
         res_min_q <= res_min_d;
         res_max_q <= res_max_d;
      end
   assign res_min = res_min_q;
   assign res_max = res_max_q;
`endif

   assign tdc_en      = state_q == WAIT;
   assign tdc_clr     = state_q == ARM;
   assign busy        = state_q != IDLE;
   assign err_timeout = err_q;
   assign res_time    = res_time_q;
   assign res_valid   = res_valid_q;
   assign meas_cnt    = meas_cnt_q;
endmodule
